// File: rtl/decode_pkg.sv
// Shared decode constants: opcodes, ctrl bit positions, ALU codes, immediate formats
// and helpers for building control words and 32-bit immediates.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam int CTRL_REG_WRITE  = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_MEM_WRITE  = 4;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_ALU_SRC    = 2;
    localparam int CTRL_ALU_OP_MSB = 1;
    localparam int CTRL_ALU_OP_LSB = 0;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    function automatic logic [7:0] mk_ctrl(
        input logic       reg_write,
        input logic       mem_to_reg,
        input logic       mem_read,
        input logic       mem_write,
        input logic       branch,
        input logic       alu_src,
        input logic [1:0] alu_op
    );
        logic [7:0] c;
        c                                  = 8'h00;
        c[CTRL_REG_WRITE]                  = reg_write;
        c[CTRL_MEM_TO_REG]                 = mem_to_reg;
        c[CTRL_MEM_READ]                   = mem_read;
        c[CTRL_MEM_WRITE]                  = mem_write;
        c[CTRL_BRANCH]                     = branch;
        c[CTRL_ALU_SRC]                    = alu_src;
        c[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = alu_op;
        return c;
    endfunction

    // Sign-extended 32-bit immediate; callers widen to XLEN with a signed cast.
    function automatic logic [31:0] imm32(input logic [31:0] ins, input imm_fmt_e fmt);
        logic [31:0] v;
        case (fmt)
            FMT_I:   v = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   v = {ins[31:12], 12'h000};
            FMT_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/decode/write-back bundle of decode_stage; master drives the fetch and
// control side, slave is the decode stage itself.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            valid_in;
    logic [XLEN-1:0] pc_in;
    logic [31:0]     instr_in;
    logic            stall;
    logic            flush;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            ex_mem_read;
    logic [4:0]      ex_rd;

    logic            hazard;
    logic            valid_out;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_ctrl;
    logic [7:0]      ctrl;

    modport master (
        output valid_in, pc_in, instr_in, stall, flush,
        output wb_en, wb_addr, wb_data, ex_mem_read, ex_rd,
        input  hazard, valid_out, pc_out, rs1_data, rs2_data, imm,
        input  rs1, rs2, rd, alu_ctrl, ctrl
    );

    modport slave (
        input  valid_in, pc_in, instr_in, stall, flush,
        input  wb_en, wb_addr, wb_data, ex_mem_read, ex_rd,
        output hazard, valid_out, pc_out, rs1_data, rs2_data, imm,
        output rs1, rs2, rd, alu_ctrl, ctrl
    );
endinterface

// File: rtl/decode_stage_reg_file.sv
// Register file: two combinational read ports, one write port, x0 hard-wired to zero.
// DECODE_WB_BYPASS_EN forwards a same-cycle write to the read ports.
module reg_file #(
    parameter int  XLEN  = 32,
    parameter int  NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_wr_en,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [XLEN-1:0] i_wr_data
);
    logic [XLEN-1:0] r_mem [NREGS];
    logic            w_wr_ok;

    assign w_wr_ok = i_wr_en && (i_wr_addr != '0) && (int'(i_wr_addr) < NREGS);

    // Storage update; no reset so contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port 1 (indices beyond NREGS read as zero on the 16-entry variant).
    always_comb begin
        o_rs1_data = '0;
        if ((i_rs1_addr == 5'd0) || (int'(i_rs1_addr) >= NREGS)) begin
            o_rs1_data = '0;
`ifdef DECODE_WB_BYPASS_EN
        end else if (w_wr_ok && (i_rs1_addr == 5'(i_wr_addr))) begin
            o_rs1_data = i_wr_data;
`endif
        end else begin
            o_rs1_data = r_mem[i_rs1_addr[AW-1:0]];
        end
    end

    // Read port 2.
    always_comb begin
        o_rs2_data = '0;
        if ((i_rs2_addr == 5'd0) || (int'(i_rs2_addr) >= NREGS)) begin
            o_rs2_data = '0;
`ifdef DECODE_WB_BYPASS_EN
        end else if (w_wr_ok && (i_rs2_addr == 5'(i_wr_addr))) begin
            o_rs2_data = i_wr_data;
`endif
        end else begin
            o_rs2_data = r_mem[i_rs2_addr[AW-1:0]];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: instruction decode, load-use hazard detection and the
// ID/EX pipeline register. Optional DECODE_WB_BYPASS_EN enables write-back forwarding.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1_f;
    logic [4:0]      w_rs2_f;
    logic [4:0]      w_rd_f;
    logic [2:0]      w_funct3;
    logic            w_funct7_b5;
    imm_fmt_e        w_fmt;
    logic [7:0]      w_ctrl;
    logic            w_legal;
    logic [3:0]      w_alu_ctrl;
    logic [XLEN-1:0] w_imm;
    logic            w_uses_rs2;
    logic            w_hazard;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [3:0]      r_alu_ctrl;
    logic [7:0]      r_ctrl;

    assign w_opcode    = bus.instr_in[6:0];
    assign w_rd_f      = bus.instr_in[11:7];
    assign w_funct3    = bus.instr_in[14:12];
    assign w_rs1_f     = bus.instr_in[19:15];
    assign w_rs2_f     = bus.instr_in[24:20];
    assign w_funct7_b5 = bus.instr_in[30];

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk        (clk),
        .i_rs1_addr (w_rs1_f),
        .o_rs1_data (w_rs1_data),
        .i_rs2_addr (w_rs2_f),
        .o_rs2_data (w_rs2_data),
        .i_wr_en    (bus.wb_en),
        .i_wr_addr  (bus.wb_addr),
        .i_wr_data  (bus.wb_data)
    );

    // Opcode decode: immediate format and control word; unknown opcodes stay illegal.
    always_comb begin
        w_fmt   = FMT_R;
        w_ctrl  = 8'h00;
        w_legal = 1'b0;
        case (w_opcode)
            OPC_LOAD: begin
                w_fmt   = FMT_I;
                w_ctrl  = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ALUOP_ADD);
                w_legal = 1'b1;
            end
            OPC_STORE: begin
                w_fmt   = FMT_S;
                w_ctrl  = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ALUOP_ADD);
                w_legal = 1'b1;
            end
            OPC_OP: begin
                w_fmt   = FMT_R;
                w_ctrl  = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT);
                w_legal = 1'b1;
            end
            OPC_OP_IMM: begin
                w_fmt   = FMT_I;
                w_ctrl  = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_FUNCT);
                w_legal = 1'b1;
            end
            OPC_BRANCH: begin
                w_fmt   = FMT_B;
                w_ctrl  = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_BRANCH);
                w_legal = 1'b1;
            end
            OPC_JAL: begin
                w_fmt   = FMT_J;
                w_ctrl  = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD);
                w_legal = 1'b1;
            end
            OPC_JALR: begin
                w_fmt   = FMT_I;
                w_ctrl  = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_ADD);
                w_legal = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_fmt   = FMT_U;
                w_ctrl  = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_ADD);
                w_legal = 1'b1;
            end
            default: begin
                w_fmt   = FMT_R;
                w_ctrl  = 8'h00;
                w_legal = 1'b0;
            end
        endcase
    end

    // ALU operation; SUB from funct7 only applies to register-register ops.
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        case (w_ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB])
            ALUOP_ADD:    w_alu_ctrl = ALU_ADD;
            ALUOP_BRANCH: w_alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (w_funct3)
                    3'b000: begin
                        if ((w_opcode == OPC_OP) && w_funct7_b5) begin
                            w_alu_ctrl = ALU_SUB;
                        end else begin
                            w_alu_ctrl = ALU_ADD;
                        end
                    end
                    3'b111:  w_alu_ctrl = ALU_AND;
                    3'b110:  w_alu_ctrl = ALU_OR;
                    3'b010:  w_alu_ctrl = ALU_SLT;
                    default: w_alu_ctrl = ALU_ADD;
                endcase
            end
            default: w_alu_ctrl = ALU_ADD;
        endcase
    end

    assign w_imm = XLEN'($signed(imm32(bus.instr_in, w_fmt)));

    // Load-use hazard; rs2 only counts for formats that actually read it.
    always_comb begin
        w_uses_rs2 = 1'b0;
        w_hazard   = 1'b0;
        if ((w_opcode == OPC_OP) || (w_opcode == OPC_STORE) || (w_opcode == OPC_BRANCH)) begin
            w_uses_rs2 = 1'b1;
        end else begin
            w_uses_rs2 = 1'b0;
        end
        if (bus.ex_mem_read && (bus.ex_rd != 5'd0) && bus.valid_in) begin
            w_hazard = (bus.ex_rd == w_rs1_f) || ((bus.ex_rd == w_rs2_f) && w_uses_rs2);
        end else begin
            w_hazard = 1'b0;
        end
    end

    // ID/EX register: reset > flush > stall > bubble (hazard, no valid, illegal) > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_alu_ctrl <= 4'd0;
            r_ctrl     <= 8'h00;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= 8'h00;
        end else if (bus.stall) begin
            r_valid <= r_valid;
            r_ctrl  <= r_ctrl;
        end else if (w_hazard || !bus.valid_in || !w_legal) begin
            r_valid <= 1'b0;
            r_ctrl  <= 8'h00;
        end else begin
            r_valid    <= 1'b1;
            r_pc       <= bus.pc_in;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_imm      <= w_imm;
            r_rs1      <= w_rs1_f;
            r_rs2      <= w_rs2_f;
            r_rd       <= w_rd_f;
            r_alu_ctrl <= w_alu_ctrl;
            r_ctrl     <= w_ctrl;
        end
    end

    assign bus.hazard    = w_hazard;
    assign bus.valid_out = r_valid;
    assign bus.pc_out    = r_pc;
    assign bus.rs1_data  = r_rs1_data;
    assign bus.rs2_data  = r_rs2_data;
    assign bus.imm       = r_imm;
    assign bus.rs1       = r_rs1;
    assign bus.rs2       = r_rs2;
    assign bus.rd        = r_rd;
    assign bus.alu_ctrl  = r_alu_ctrl;
    assign bus.ctrl      = r_ctrl;

endmodule
